// File: rtl/structural_project.sv
`default_nettype none
// ============================================================================
//  Module   : structural_project
//  Purpose  : Gate-level decoder of a 4-bit code {a,b,c,d} into prime,
//             divisible-by-3 and odd-parity flags, registered on clk.
//  Revision : 1.0  initial release
// ============================================================================
module structural_project (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic F1,
    output logic F2,
    output logic F3
);

    logic w_na;
    logic w_nb;
    logic w_nc;
    logic w_nd;

    not u_inv_a (w_na, a);
    not u_inv_b (w_nb, b);
    not u_inv_c (w_nc, c);
    not u_inv_d (w_nd, d);

    // Prime: a'b'c + a'bd + b'cd + bc'd, built as NAND-NAND
    logic w_p0_n;
    logic w_p1_n;
    logic w_p2_n;
    logic w_p3_n;
    logic w_f1;

    nand u_p0 (w_p0_n, w_na, w_nb, c);
    nand u_p1 (w_p1_n, w_na, b, d);
    nand u_p2 (w_p2_n, w_nb, c, d);
    nand u_p3 (w_p3_n, b, w_nc, d);
    nand u_f1 (w_f1, w_p0_n, w_p1_n, w_p2_n, w_p3_n);

    // Divisible by 3: sum of minterms 0, 3, 6, 9, 12, 15
    logic w_m0;
    logic w_m3;
    logic w_m6;
    logic w_m9;
    logic w_m12;
    logic w_m15;
    logic w_f2;

    and u_m0  (w_m0,  w_na, w_nb, w_nc, w_nd);
    and u_m3  (w_m3,  w_na, w_nb, c,    d);
    and u_m6  (w_m6,  w_na, b,    c,    w_nd);
    and u_m9  (w_m9,  a,    w_nb, w_nc, d);
    and u_m12 (w_m12, a,    b,    w_nc, w_nd);
    and u_m15 (w_m15, a,    b,    c,    d);
    or  u_f2  (w_f2, w_m0, w_m3, w_m6, w_m9, w_m12, w_m15);

    logic w_x_ab;
    logic w_x_cd;
    logic w_f3;

    xor u_x_ab (w_x_ab, a, b);
    xor u_x_cd (w_x_cd, c, d);
    xor u_f3   (w_f3, w_x_ab, w_x_cd);

    logic [2:0] r_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 3'b000;
        end else begin
            r_flags <= {w_f1, w_f2, w_f3};
        end
    end

    assign F1 = r_flags[2];
    assign F2 = r_flags[1];
    assign F3 = r_flags[0];

endmodule
`default_nettype wire

// File: tb/tb_structural_project.sv
`default_nettype none
// ============================================================================
//  Module   : tb_structural_project
//  Purpose  : Self-checking bench for structural_project against an
//             arithmetic reference model of the three flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_structural_project;

    logic clk = 1'b0;
    logic rst;
    logic a;
    logic b;
    logic c;
    logic d;
    logic F1;
    logic F2;
    logic F3;

    int n_checks = 0;
    int n_fails  = 0;

    structural_project dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .F1  (F1),
        .F2  (F2),
        .F3  (F3)
    );

    always #5 clk = ~clk;

    task automatic check_flags(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed F1F2F3=%b expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: flags computed directly from the integer value of the code
    function automatic logic [2:0] ref_flags(input int n);
        logic is_prime;
        logic div3;
        logic odd;
        is_prime = 1'b0;
        if (n >= 2) begin
            is_prime = 1'b1;
            for (int k = 2; k < n; k++)
                if (n % k == 0) is_prime = 1'b0;
        end
        div3 = (n % 3 == 0);
        odd  = (((n >> 3) + (n >> 2) + (n >> 1) + n) & 1) != 0 ?
               ((((n >> 3) & 1) + ((n >> 2) & 1) + ((n >> 1) & 1) + (n & 1)) % 2 == 1) :
               ((((n >> 3) & 1) + ((n >> 2) & 1) + ((n >> 1) & 1) + (n & 1)) % 2 == 1);
        return {is_prime, div3, odd};
    endfunction

    task automatic apply_code(input int n);
        a = ((n >> 3) & 1) != 0;
        b = ((n >> 2) & 1) != 0;
        c = ((n >> 1) & 1) != 0;
        d = (n & 1) != 0;
    endtask

    function automatic logic [2:0] outs();
        return {F1, F2, F3};
    endfunction

    logic [2:0] expected;
    int         n_rand;

    initial begin
        rst = 1'b1;
        apply_code(0);

        // Reset held: outputs zero before and across clock edges
        #1 check_flags("reset_async", outs(), 3'b000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_flags("reset_held", outs(), 3'b000);
        end

        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check_flags("reset_release_n0", outs(), ref_flags(0));

        // Exhaustive sweep
        for (int n = 0; n < 16; n++) begin
            @(negedge clk) apply_code(n);
            @(posedge clk); #1;
            check_flags($sformatf("sweep_n%0d", n), outs(), ref_flags(n));
        end

        // Latency: mid-cycle change is not visible until next edge
        @(negedge clk) apply_code(7);
        @(posedge clk); #1;
        check_flags("latency_n7", outs(), ref_flags(7));
        #1 apply_code(8);
        #1 check_flags("latency_hold", outs(), ref_flags(7));
        @(posedge clk); #1;
        check_flags("latency_n8", outs(), ref_flags(8));

        // Asynchronous reset between edges
        @(negedge clk) apply_code(11);
        @(posedge clk); #1;
        check_flags("pre_reset_n11", outs(), ref_flags(11));
        @(negedge clk) rst = 1'b1;
        #1 check_flags("mid_reset", outs(), 3'b000);
        #1 rst = 1'b0;
        #1 check_flags("post_reset_noedge", outs(), 3'b000);
        @(posedge clk); #1;
        check_flags("post_reset_n11", outs(), ref_flags(11));

        // Glitch immunity: d pulses between edges while N=2
        @(negedge clk) apply_code(10);
        @(posedge clk); #1;
        check_flags("glitch_pre_n10", outs(), ref_flags(10));
        @(negedge clk) apply_code(2);
        #1 d = 1'b1;
        #1 d = 1'b0;
        #1 check_flags("glitch_hold", outs(), ref_flags(10));
        @(posedge clk); #1;
        check_flags("glitch_n2", outs(), ref_flags(2));

        // Randomized codes with occasional asynchronous reset pulses
        expected = ref_flags(2);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n_rand = int'($urandom_range(0, 15));
            apply_code(n_rand);
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                #1 check_flags("rand_reset", outs(), 3'b000);
                #1 rst = 1'b0;
            end else begin
                #1 check_flags("rand_hold", outs(), expected);
            end
            @(posedge clk); #1;
            expected = ref_flags(n_rand);
            check_flags($sformatf("rand_n%0d", n_rand), outs(), expected);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/structural_project.md
Name: structural_project

Overview:
- Gate-level combinational decoder of a 4-bit input code {a,b,c,d}, with `a` as the MSB, giving N = 8a+4b+2c+d.
- Produces three flag functions of N: prime, divisible-by-3, odd parity.
- The three flags are registered on the clock and driven to the outputs.
- Used as a small structural logic leaf that is checked exhaustively over all 16 minterms.

Parameters:
- None. All widths are fixed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- F1  output  1  registered flag: N is prime.
- F2  output  1  registered flag: N is divisible by 3.
- F3  output  1  registered flag: odd parity of {a,b,c,d}.
- a  input  1  code bit 3 (MSB).
- b  input  1  code bit 2.
- c  input  1  code bit 1.
- d  input  1  code bit 0 (LSB).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Next-state logic is built structurally from gate primitives only: not, and, or, xor, nand, nor. No behavioural operators and no arithmetic on N.
- Next-state functions, as minterms of N:
  - f1 = Σm(2,3,5,7,11,13). Example SOP: a'b'c + a'bd + b'cd + bc'd.
  - f2 = Σm(0,3,6,9,12,15).
  - f3 = a ^ b ^ c ^ d, equivalently Σm(1,2,4,7,8,11,13,14).
- Registers:
  - Three flip-flops capture f1, f2, f3 on each rising edge of clk.
  - F1/F2/F3 are the direct flop outputs.
- Latency: an input change applied before edge k appears on F1..F3 immediately after edge k (1 cycle).
  - Outputs are stable for the full cycle.
  - There is no combinational path from inputs to outputs.
- Reset:
  - While rst=1, F1=F2=F3=0 immediately, with no clock needed. This holds even though f2(N=0)=1.
  - Reset asserted mid-operation clears the outputs at once.
- Reset release:
  - The first rising edge with rst=0 loads the current f1..f3.
  - A reset deasserted coincident with an edge must not corrupt state: either the 0 is held or the valid next value is loaded, never X.
- Inputs are sampled only at rising edges. Glitches between edges have no effect.
- Unknown inputs (X/Z) are outside the specification. The outputs are then unspecified, but a clean input must recover the correct value after one edge.
- Boundary values:
  - N=0 gives F2=1, F1=0, F3=0.
  - N=15 gives F2=1, F1=0, F3=0.
  - N=1 is not prime: F1=0.
- Full 16-row truth table, listed as N: F1 F2 F3:
  - 0:010, 1:001, 2:101, 3:110
  - 4:001, 5:100, 6:010, 7:101
  - 8:001, 9:010, 10:000, 11:101
  - 12:010, 13:101, 14:001, 15:010

Test Plan:
1. Reset behaviour:
   - Hold rst=1 with {a,b,c,d}=0000 and toggle clk: F1F2F3=000 throughout.
   - Release rst, then one edge: F1F2F3=010.
2. Exhaustive sweep:
   - Apply N=0..15, one per clock.
   - After each edge, the outputs equal the truth-table row of the N applied before that edge. Examples: N=13 gives 101, N=10 gives 000, N=6 gives 010.
3. Latency check:
   - Change inputs from 0111 to 1000 mid-cycle: outputs stay 101 until the next rising edge, then become 001.
4. Asynchronous reset mid-operation:
   - With N=11 loaded (outputs 101), pulse rst between edges: outputs go to 000 without a clock edge.
   - After release, the next edge restores 101.
5. Input glitch immunity:
   - Between edges, pulse d 0→1→0 while N=2.
   - Outputs remain at the value captured at the last edge; the next edge shows 101.
